// File: rtl/mio_bus_if.sv
// CPU/RAM/IO bus bundle for mio_bus. The slave modport is the bridge view;
// the master modport is the view of whoever drives the CPU, RAM and IO sides.
interface mio_bus_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              mem_r;
    logic              mem_w;
    logic [31:0]       addr;
    logic [31:0]       data_w;
    logic [31:0]       data_r;
    logic              mio_ready;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;
    logic              io_en;
    logic              io_we;
    logic [7:0]        io_addr;
    logic [31:0]       io_wdata;
    logic [31:0]       io_rdata;
    logic              io_ack;
    logic              bus_err;

    modport slave (
        input  mem_r, mem_w, addr, data_w, ram_dout, io_rdata, io_ack,
        output data_r, mio_ready, ram_en, ram_we, ram_addr, ram_din,
               io_en, io_we, io_addr, io_wdata, bus_err
    );

    modport master (
        output mem_r, mem_w, addr, data_w, ram_dout, io_rdata, io_ack,
        input  data_r, mio_ready, ram_en, ram_we, ram_addr, ram_din,
               io_en, io_we, io_addr, io_wdata, bus_err
    );
endinterface

// File: rtl/mio_bus.sv
// Memory/IO bridge: routes one CPU load/store at a time to a fixed-latency RAM
// or an acked IO page, with timeout and a sticky error flag. All outputs registered.
module mio_bus #(
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned ADDR_W      = 10,
    parameter logic [23:0] IO_PAGE     = 24'hFFFFFF,
    parameter int unsigned IO_TIMEOUT  = 15
) (
    input logic        clk,
    input logic        reset,
    mio_bus_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StRamWait, StIoWait, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic [3:0]        ram_cnt_q, ram_cnt_d;
    logic [7:0]        io_cnt_q, io_cnt_d;
    logic              we_q, we_d;
    logic [31:0]       data_r_q, data_r_d;
    logic              mio_ready_q, mio_ready_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_din_q, ram_din_d;
    logic              io_en_q, io_en_d;
    logic              io_we_q, io_we_d;
    logic [7:0]        io_addr_q, io_addr_d;
    logic [31:0]       io_wdata_q, io_wdata_d;
    logic              bus_err_q, bus_err_d;

    always_comb begin
        state_d     = state_q;
        ram_cnt_d   = ram_cnt_q;
        io_cnt_d    = io_cnt_q;
        we_d        = we_q;
        data_r_d    = data_r_q;
        mio_ready_d = 1'b0;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        io_en_d     = io_en_q;
        io_we_d     = io_we_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        bus_err_d   = bus_err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.mem_r || bus.mem_w) begin
                    we_d = bus.mem_w;
                    if (bus.addr[1:0] != 2'b00) begin
                        state_d   = StErr;
                        bus_err_d = 1'b1;
                    end else if (bus.addr[31:8] == IO_PAGE) begin
                        state_d    = StIoWait;
                        io_cnt_d   = 8'd0;
                        io_en_d    = 1'b1;
                        io_we_d    = bus.mem_w;
                        io_addr_d  = bus.addr[7:0];
                        io_wdata_d = bus.data_w;
                    end else begin
                        state_d    = StRamWait;
                        ram_cnt_d  = 4'd0;
                        ram_en_d   = 1'b1;
                        ram_we_d   = bus.mem_w;
                        ram_addr_d = bus.addr[ADDR_W+1:2];
                        ram_din_d  = bus.data_w;
                    end
                end
            end
            StRamWait: begin
                if (ram_cnt_q == 4'(RAM_LATENCY - 1)) begin
                    if (!we_q) data_r_d = bus.ram_dout;
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                    state_d  = StDone;
                end else begin
                    ram_cnt_d = ram_cnt_q + 4'd1;
                end
            end
            StIoWait: begin
                // An ack on the timeout cycle wins over the timeout.
                if (bus.io_ack) begin
                    if (!we_q) data_r_d = bus.io_rdata;
                    io_en_d = 1'b0;
                    io_we_d = 1'b0;
                    state_d = StDone;
                end else if (io_cnt_q == 8'(IO_TIMEOUT - 1)) begin
                    bus_err_d = 1'b1;
                    data_r_d  = 32'h0;
                    io_en_d   = 1'b0;
                    io_we_d   = 1'b0;
                    state_d   = StDone;
                end else begin
                    io_cnt_d = io_cnt_q + 8'd1;
                end
            end
            StDone: begin
                mio_ready_d = 1'b1;
                state_d     = StIdle;
            end
            StErr: begin
                state_d = StErr;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ram_cnt_q   <= 4'd0;
            io_cnt_q    <= 8'd0;
            we_q        <= 1'b0;
            data_r_q    <= 32'h0;
            mio_ready_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= 32'h0;
            io_en_q     <= 1'b0;
            io_we_q     <= 1'b0;
            io_addr_q   <= 8'h0;
            io_wdata_q  <= 32'h0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_cnt_q   <= ram_cnt_d;
            io_cnt_q    <= io_cnt_d;
            we_q        <= we_d;
            data_r_q    <= data_r_d;
            mio_ready_q <= mio_ready_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            io_en_q     <= io_en_d;
            io_we_q     <= io_we_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.data_r    = data_r_q;
    assign bus.mio_ready = mio_ready_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.io_en     = io_en_q;
    assign bus.io_we     = io_we_q;
    assign bus.io_addr   = io_addr_q;
    assign bus.io_wdata  = io_wdata_q;
    assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mio_bus.sv
// Directed bench for mio_bus: RAM/IO reads and writes, timeout, misalignment,
// back-to-back and held requests, and reset mid-transaction.
module tb_mio_bus;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    mio_bus_if #(.ADDR_W(10)) bus ();

    mio_bus #(
        .RAM_LATENCY(2),
        .ADDR_W     (10),
        .IO_PAGE    (24'hFFFFFF),
        .IO_TIMEOUT (15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.mem_r    = 1'b0;
        bus.mem_w    = 1'b0;
        bus.addr     = 32'h0;
        bus.data_w   = 32'h0;
        bus.ram_dout = 32'h0;
        bus.io_rdata = 32'h0;
        bus.io_ack   = 1'b0;

        step();
        step();
        chk("rst_data_r", bus.data_r, 32'h0);
        chk("rst_ready", bus.mio_ready, 1'b0);
        chk("rst_ram_en", bus.ram_en, 1'b0);
        chk("rst_io_en", bus.io_en, 1'b0);
        chk("rst_bus_err", bus.bus_err, 1'b0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        reset = 1'b0;

        // RAM read, latency 2: ready after posedge k+3
        bus.mem_r = 1'b1; bus.addr = 32'h10; bus.ram_dout = 32'hDEADBEEF;
        step();
        chk("rd_ram_en", bus.ram_en, 1'b1);
        chk("rd_ram_we", bus.ram_we, 1'b0);
        chk("rd_ram_addr", 32'(bus.ram_addr), 32'h4);
        bus.mem_r = 1'b0; bus.addr = 32'h20;
        step();
        chk("rd_k1_ram_en", bus.ram_en, 1'b1);
        chk("rd_k1_ready", bus.mio_ready, 1'b0);
        chk("rd_addr_held", 32'(bus.ram_addr), 32'h4);
        bus.ram_dout = 32'hCAFEF00D;
        step();
        chk("rd_k2_ram_en", bus.ram_en, 1'b0);
        chk("rd_k2_ready", bus.mio_ready, 1'b0);
        chk("rd_data_r", bus.data_r, 32'hCAFEF00D);
        step();
        chk("rd_k3_ready", bus.mio_ready, 1'b1);
        step();
        chk("rd_k4_ready", bus.mio_ready, 1'b0);

        // IO write, ack sampled 3 cycles after io_en rises
        bus.mem_w = 1'b1; bus.addr = 32'hFFFFFF04; bus.data_w = 32'h5A;
        bus.io_rdata = 32'h12345678;
        step();
        chk("iow_io_en", bus.io_en, 1'b1);
        chk("iow_io_we", bus.io_we, 1'b1);
        chk("iow_io_addr", 32'(bus.io_addr), 32'h04);
        chk("iow_io_wdata", bus.io_wdata, 32'h5A);
        chk("iow_ram_en", bus.ram_en, 1'b0);
        bus.mem_w = 1'b0;
        step();
        step();
        chk("iow_wait_io_en", bus.io_en, 1'b1);
        chk("iow_wait_ready", bus.mio_ready, 1'b0);
        bus.io_ack = 1'b1;
        step();
        bus.io_ack = 1'b0;
        chk("iow_ack_io_en", bus.io_en, 1'b0);
        chk("iow_ack_io_we", bus.io_we, 1'b0);
        step();
        chk("iow_ready", bus.mio_ready, 1'b1);
        chk("iow_data_r_kept", bus.data_r, 32'hCAFEF00D);
        chk("iow_bus_err", bus.bus_err, 1'b0);
        step();
        chk("iow_ready_off", bus.mio_ready, 1'b0);

        // IO read with immediate ack
        bus.mem_r = 1'b1; bus.addr = 32'hFFFFFF08; bus.io_rdata = 32'hA5A50001;
        step();
        chk("ior_io_we", bus.io_we, 1'b0);
        chk("ior_io_addr", 32'(bus.io_addr), 32'h08);
        bus.mem_r = 1'b0; bus.io_ack = 1'b1;
        step();
        bus.io_ack = 1'b0;
        chk("ior_data_r", bus.data_r, 32'hA5A50001);
        step();
        chk("ior_ready", bus.mio_ready, 1'b1);
        step();

        // IO timeout: 15 unacked cycles
        bus.mem_r = 1'b1; bus.addr = 32'hFFFFFF10;
        step();
        bus.mem_r = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("to_pre_io_en", bus.io_en, 1'b1);
        chk("to_pre_bus_err", bus.bus_err, 1'b0);
        step();
        chk("to_io_en", bus.io_en, 1'b0);
        chk("to_bus_err", bus.bus_err, 1'b1);
        chk("to_data_r", bus.data_r, 32'h0);
        chk("to_not_ready", bus.mio_ready, 1'b0);
        step();
        chk("to_ready", bus.mio_ready, 1'b1);
        step();
        chk("to_ready_off", bus.mio_ready, 1'b0);
        chk("to_idle_io_en", bus.io_en, 1'b0);

        reset = 1'b1;
        #1;
        chk("rst2_bus_err", bus.bus_err, 1'b0);
        step();
        reset = 1'b0;

        // Ack on the timeout cycle counts as ack
        bus.mem_r = 1'b1; bus.addr = 32'hFFFFFF20; bus.io_rdata = 32'h0BADF00D;
        step();
        bus.mem_r = 1'b0;
        for (int i = 0; i < 14; i++) step();
        bus.io_ack = 1'b1;
        step();
        bus.io_ack = 1'b0;
        chk("toack_bus_err", bus.bus_err, 1'b0);
        chk("toack_data_r", bus.data_r, 32'h0BADF00D);
        step();
        chk("toack_ready", bus.mio_ready, 1'b1);

        // Back-to-back: RAM write then RAM read, read held through DONE
        bus.mem_w = 1'b1; bus.addr = 32'h40; bus.data_w = 32'h11;
        step();
        chk("b2b_w_ram_we", bus.ram_we, 1'b1);
        chk("b2b_w_ram_din", bus.ram_din, 32'h11);
        chk("b2b_w_ram_addr", 32'(bus.ram_addr), 32'h10);
        bus.ram_dout = 32'h99999999;
        step();
        step();
        chk("b2b_w_data_r_kept", bus.data_r, 32'h0BADF00D);
        step();
        chk("b2b_w_ready", bus.mio_ready, 1'b1);
        bus.mem_w = 1'b0; bus.mem_r = 1'b1; bus.addr = 32'h44; bus.ram_dout = 32'h77;
        step();
        chk("b2b_r_ready_off", bus.mio_ready, 1'b0);
        chk("b2b_r_ram_en", bus.ram_en, 1'b1);
        chk("b2b_r_ram_addr", 32'(bus.ram_addr), 32'h11);
        step();
        step();
        chk("b2b_r_data_r", bus.data_r, 32'h77);
        chk("b2b_done_ram_en", bus.ram_en, 1'b0);
        step();
        chk("b2b_r_ready", bus.mio_ready, 1'b1);
        chk("hold_no_reaccept", bus.ram_en, 1'b0);
        bus.mem_r = 1'b0;
        step();
        chk("hold_one_pulse", bus.mio_ready, 1'b0);
        chk("hold_ram_en", bus.ram_en, 1'b0);

        // Misaligned access locks in ERR until reset
        bus.mem_r = 1'b1; bus.addr = 32'h6;
        step();
        chk("mis_bus_err", bus.bus_err, 1'b1);
        chk("mis_ram_en", bus.ram_en, 1'b0);
        chk("mis_io_en", bus.io_en, 1'b0);
        bus.mem_r = 1'b0;
        step();
        step();
        chk("mis_ready_a", bus.mio_ready, 1'b0);
        bus.mem_r = 1'b1; bus.addr = 32'h8;
        step();
        step();
        chk("mis_ready_b", bus.mio_ready, 1'b0);
        chk("mis_stuck_ram_en", bus.ram_en, 1'b0);
        chk("mis_bus_err_held", bus.bus_err, 1'b1);
        bus.mem_r = 1'b0;
        reset = 1'b1;
        #1;
        chk("mis_rst_bus_err", bus.bus_err, 1'b0);
        step();
        reset = 1'b0;

        // Reset during RAM_WAIT abandons the transaction
        bus.mem_r = 1'b1; bus.addr = 32'h80;
        step();
        chk("mid_ram_en", bus.ram_en, 1'b1);
        bus.mem_r = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_ram_en_drop", bus.ram_en, 1'b0);
        step();
        reset = 1'b0;
        step();
        step();
        step();
        chk("mid_no_ready", bus.mio_ready, 1'b0);
        chk("mid_data_r", bus.data_r, 32'h0);

        // First request after reset completes normally
        bus.mem_r = 1'b1; bus.addr = 32'h84; bus.ram_dout = 32'h0000BEEF;
        step();
        chk("post_ram_addr", 32'(bus.ram_addr), 32'h21);
        bus.mem_r = 1'b0;
        step();
        step();
        step();
        chk("post_ready", bus.mio_ready, 1'b1);
        chk("post_data_r", bus.data_r, 32'h0000BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mio_bus.md
MIO_BUS -- requirements
Module: mio_bus

Interface
REQ-001 Parameters (name, default, meaning):
- RAM_LATENCY, 2: RAM wait cycles, legal 1..15.
- ADDR_W, 10: RAM word-address width.
- IO_PAGE, 24'hFFFFFF: addr[31:8] value that selects I/O space.
- IO_TIMEOUT, 15: maximum I/O wait cycles, legal 1..255.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state updates on posedge.
- reset, in, 1: asynchronous, active-high reset.
- mem_r, in, 1: CPU read request (MemRead), a level.
- mem_w, in, 1: CPU write request (MemWrite), a level.
- addr, in, 32: CPU byte address.
- data_w, in, 32: CPU store data.
- data_r, out, 32: load data returned to the CPU.
- mio_ready, out, 1: one-cycle completion pulse to the control FSM.
- ram_en, out, 1: RAM enable.
- ram_we, out, 1: RAM write enable.
- ram_addr, out, ADDR_W: RAM word address.
- ram_din, out, 32: RAM write data.
- ram_dout, in, 32: RAM read data.
- io_en, out, 1: I/O strobe.
- io_we, out, 1: I/O write enable.
- io_addr, out, 8: I/O register offset.
- io_wdata, out, 32: I/O write data.
- io_rdata, in, 32: I/O read data.
- io_ack, in, 1: I/O completion.
- bus_err, out, 1: sticky error flag.

Function
REQ-003 States: IDLE, RAM_WAIT, IO_WAIT, DONE, ERR. All outputs are registered.

REQ-004 IDLE, with mem_r or mem_w high at a posedge, the request is accepted:
- Latch addr, data_w and we = mem_w; mem_w takes priority when both are high.
- addr[1:0] != 0: go to ERR and set bus_err.
- addr[31:8] == IO_PAGE: go to IO_WAIT.
- Otherwise: go to RAM_WAIT.

REQ-005 Once a request is accepted, changes on addr, data_w, mem_r and mem_w are ignored until the FSM returns to IDLE.

REQ-006 RAM_WAIT:
- Drive ram_en=1, ram_we=we, ram_addr=latched addr[ADDR_W+1:2], ram_din=latched data.
- A 4-bit counter starts at 0 and increments each cycle.
- On the cycle the counter equals RAM_LATENCY-1: capture ram_dout into data_r (reads only), drop ram_en/ram_we, go to DONE.

REQ-007 RAM latency: request sampled at posedge k gives mio_ready high during the cycle after posedge k+RAM_LATENCY+1.

REQ-008 IO_WAIT:
- Drive io_en=1, io_we=we, io_addr=latched addr[7:0], io_wdata=latched data.
- io_ack high: capture io_rdata (reads only), drop io_en/io_we, go to DONE.

REQ-009 IO_WAIT timeout:
- An 8-bit counter reaching IO_TIMEOUT without io_ack sets bus_err, sets data_r=32'h0 and goes to DONE, so the CPU never hangs.
- io_ack arriving on the same cycle as the timeout counts as an ack; bus_err is not set.

REQ-010 DONE:
- mio_ready=1 for exactly one cycle, then unconditionally go to IDLE.
- A request still asserted during DONE is not re-accepted.
- Back-to-back requests therefore have at least one IDLE cycle between them.

REQ-011 ERR:
- Terminal state: mio_ready stays 0 and bus_err stays 1.
- Only reset leaves ERR.

REQ-012 data_r holds its last captured value except as written in REQ-006/REQ-008/REQ-009. Writes do not modify data_r.

REQ-013 mio_ready, ram_en and io_en are never high in the same cycle.

Reset
REQ-014 reset high immediately (asynchronously) forces:
- state=IDLE, both counters=0;
- mio_ready, ram_en, ram_we, io_en, io_we and bus_err = 0;
- data_r, ram_addr, ram_din, io_addr and io_wdata = 0.

REQ-015 Reset asserted mid-transaction abandons the transaction; no mio_ready is produced for it.

REQ-016 After reset deasserts, the first posedge in IDLE with a request present accepts that request.

Verification
REQ-017 RAM read: RAM_LATENCY=2, mem_r=1, addr=32'h10, ram_dout=32'hCAFEF00D -> ram_addr=4; mio_ready pulses one cycle, 3 cycles after acceptance; data_r=32'hCAFEF00D.

REQ-018 I/O write: mem_w=1, addr=32'hFFFFFF04, data_w=32'h5A, io_ack high 3 cycles after io_en rises -> io_addr=8'h04, io_wdata=32'h5A, io_we=1; one mio_ready pulse; data_r unchanged.

REQ-019 I/O timeout: I/O read with io_ack held 0 -> after IO_TIMEOUT cycles bus_err=1, data_r=0, one mio_ready pulse, FSM back in IDLE.

REQ-020 Misaligned access: mem_r=1, addr=32'h6 -> ERR, bus_err=1, mio_ready never asserts; reset returns to IDLE with bus_err=0.

REQ-021 Back-to-back and held request: mem_w completes, then mem_r is asserted in the cycle after DONE -> two distinct transactions, two mio_ready pulses. A request held high through DONE produces only one pulse.

REQ-022 Reset mid-transaction: reset pulsed during RAM_WAIT -> ram_en drops the same cycle; no mio_ready; the next request completes normally.
